// File: rtl/vreg_req_sequencer_pkg.sv
// Shared core types for the lane-to-vector-register crossbar front end.
// Request bundle, access type, sizing constants and sequencer states.
package vreg_req_sequencer_pkg;

  localparam int VECTOR_REG_DEPTH  = 64;
  localparam int VECTOR_REG_WIDTH  = 64;
  localparam int NUM_OF_VECTOR_REG = 8;
  localparam int NUM_OF_PORT       = 4;
  localparam int LEN_W             = 7;

  localparam int ADDR_W = $clog2(VECTOR_REG_DEPTH);
  localparam int PTR_W  = $clog2(NUM_OF_VECTOR_REG);

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_e;

  typedef struct packed {
    logic                        vld;
    logic [PTR_W-1:0]            vec_reg_ptr;
    logic [ADDR_W-1:0]           addr;
    access_type_e                access_type;
    logic [LEN_W-1:0]            access_length;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } cntrl_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/vreg_req_sequencer.sv
// Per-port sequencer: expands one vector access command into
// single-element crossbar requests and returns read data to the lane.
module vreg_req_sequencer
  import vreg_req_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  logic                        cmd_type,
  input  logic [PTR_W-1:0]            cmd_vec_reg_ptr,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [LEN_W-1:0]            cmd_length,
  input  logic                        wdata_vld,
  input  logic [VECTOR_REG_WIDTH-1:0] wdata,
  output logic                        wdata_rdy,
  output cntrl_req_t                  req,
  input  logic                        gnt,
  input  logic                        rsp_vld,
  input  logic [VECTOR_REG_WIDTH-1:0] rd_data_in,
  output logic                        rd_vld,
  output logic [VECTOR_REG_WIDTH-1:0] rd_data,
  output logic                        done,
  output logic                        err_unexp_rsp
);

  seq_state_e                  r_state;
  seq_state_e                  w_next;
  access_type_e                r_type;
  logic [PTR_W-1:0]            r_ptr;
  logic [ADDR_W-1:0]           r_addr;
  logic [LEN_W-1:0]            r_issue_cnt;
  logic [LEN_W-1:0]            r_ret_cnt;
  logic                        r_rd_vld;
  logic [VECTOR_REG_WIDTH-1:0] r_rd_data;
  logic                        r_done;
  logic                        r_err;

  logic w_accept;
  logic w_req_vld;
  logic w_fire;
  logic w_last;
  logic w_rsp_ok;

  assign w_accept  = (r_state == ST_IDLE) & cmd_vld;
  assign w_req_vld = (r_state == ST_ISSUE) &
                     ((r_type == READ_REQ) | wdata_vld);
  assign w_fire    = w_req_vld & gnt;
  assign w_last    = w_fire & (r_issue_cnt == LEN_W'(1));
  assign w_rsp_ok  = rsp_vld & (r_ret_cnt != '0);

  always_comb begin
    w_next    = r_state;
    cmd_rdy   = 1'b0;
    wdata_rdy = 1'b0;
    req       = '0;
    unique case (r_state)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld)
          w_next = (cmd_length == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        req.vld           = w_req_vld;
        req.vec_reg_ptr   = r_ptr;
        req.addr          = r_addr;
        req.access_type   = r_type;
        req.access_length = r_issue_cnt;
        if (r_type == WRITE_REQ) begin
          req.data  = wdata;
          wdata_rdy = w_fire;
        end
        if (w_last)
          w_next = (r_type == READ_REQ) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        if ((r_ret_cnt == '0) ||
            (rsp_vld && (r_ret_cnt == LEN_W'(1))))
          w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_type      <= READ_REQ;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else if (w_accept) begin
      r_type      <= access_type_e'(cmd_type);
      r_ptr       <= cmd_vec_reg_ptr;
      r_addr      <= cmd_addr;
      r_issue_cnt <= cmd_length;
      // writes never come back, so nothing is owed on the return path
      r_ret_cnt   <= cmd_type ? '0 : cmd_length;
    end else begin
      if (w_fire) begin
        r_issue_cnt <= r_issue_cnt - LEN_W'(1);
        r_addr      <= r_addr + ADDR_W'(1);
      end
      if (w_rsp_ok)
        r_ret_cnt <= r_ret_cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rd_vld <= w_rsp_ok;
      if (w_rsp_ok)
        r_rd_data <= rd_data_in;
      r_done <= (r_state == ST_DONE);
      r_err  <= r_err | (rsp_vld & (r_ret_cnt == '0));
    end
  end

  assign rd_vld        = r_rd_vld;
  assign rd_data       = r_rd_data;
  assign done          = r_done;
  assign err_unexp_rsp = r_err;

endmodule

// File: tb/tb_vreg_req_sequencer.sv
// Directed bench for vreg_req_sequencer with a one-cycle
// crossbar response model behind the request port.
module tb_vreg_req_sequencer;
  import vreg_req_sequencer_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        cmd_vld = 1'b0;
  logic                        cmd_rdy;
  logic                        cmd_type = 1'b0;
  logic [PTR_W-1:0]            cmd_vec_reg_ptr = '0;
  logic [ADDR_W-1:0]           cmd_addr = '0;
  logic [LEN_W-1:0]            cmd_length = '0;
  logic                        wdata_vld = 1'b0;
  logic [VECTOR_REG_WIDTH-1:0] wdata = '0;
  logic                        wdata_rdy;
  cntrl_req_t                  req;
  logic                        gnt = 1'b0;
  logic                        rsp_vld;
  logic [VECTOR_REG_WIDTH-1:0] rd_data_in;
  logic                        rd_vld;
  logic [VECTOR_REG_WIDTH-1:0] rd_data;
  logic                        done;
  logic                        err_unexp_rsp;

  logic                        inj_rsp = 1'b0;
  logic                        m_rsp;
  logic [VECTOR_REG_WIDTH-1:0] m_rdat;

  int checks = 0;
  int errors = 0;

  vreg_req_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_type        (cmd_type),
    .cmd_vec_reg_ptr (cmd_vec_reg_ptr),
    .cmd_addr        (cmd_addr),
    .cmd_length      (cmd_length),
    .wdata_vld       (wdata_vld),
    .wdata           (wdata),
    .wdata_rdy       (wdata_rdy),
    .req             (req),
    .gnt             (gnt),
    .rsp_vld         (rsp_vld),
    .rd_data_in      (rd_data_in),
    .rd_vld          (rd_vld),
    .rd_data         (rd_data),
    .done            (done),
    .err_unexp_rsp   (err_unexp_rsp)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int p, input int a);
    return 64'hDA7A_0000_0000_0000 | (64'(p) << 8) | 64'(a & 63);
  endfunction

  // register file stand-in: answers every granted read one cycle later
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rsp  <= 1'b0;
      m_rdat <= '0;
    end else begin
      m_rsp  <= req.vld & gnt & (req.access_type == READ_REQ);
      m_rdat <= mk(int'(req.vec_reg_ptr), int'(req.addr));
    end
  end

  assign rsp_vld    = m_rsp | inj_rsp;
  assign rd_data_in = m_rdat;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic t, input int p, input int a,
                      input int n);
    cmd_vld         = 1'b1;
    cmd_type        = t;
    cmd_vec_reg_ptr = PTR_W'(p);
    cmd_addr        = ADDR_W'(a);
    cmd_length      = LEN_W'(n);
  endtask

  logic [63:0] wd [4];
  int          g  [6];
  int          al [6];
  int          ea [6];
  int          rdcnt;

  initial begin
    wd = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
           64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
    g  = '{1, 0, 0, 1, 0, 1};
    al = '{3, 2, 2, 2, 1, 1};
    ea = '{20, 21, 21, 21, 22, 22};

    cyc(); #1;
    chk("rst_req_vld", 64'(req.vld), 64'(0));
    chk("rst_rd_vld", 64'(rd_vld), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err_unexp_rsp), 64'(0));
    chk("rst_wdata_rdy", 64'(wdata_rdy), 64'(0));
    cyc(); reset = 1'b1;

    // read ptr3 addr10 len4, grant held
    cyc(); send(1'b0, 3, 10, 4); #1;
    chk("t1_cmd_rdy0", 64'(cmd_rdy), 64'(1));
    for (int w = 1; w <= 8; w++) begin
      cyc(); cmd_vld = 1'b0; gnt = (w <= 4); #1;
      chk("t1_req_vld", 64'(req.vld), 64'(w <= 4));
      if (w <= 4) begin
        chk("t1_addr", 64'(req.addr), 64'(10 + w - 1));
        chk("t1_alen", 64'(req.access_length), 64'(4 - (w - 1)));
        chk("t1_ptr", 64'(req.vec_reg_ptr), 64'(3));
      end
      chk("t1_rd_vld", 64'(rd_vld), 64'(w >= 3 && w <= 6));
      if (w >= 3 && w <= 6)
        chk("t1_rd_data", rd_data, mk(3, 10 + w - 3));
      chk("t1_done", 64'(done), 64'(w == 7));
      chk("t1_cmd_rdy", 64'(cmd_rdy), 64'(w >= 7));
    end

    // write ptr5 addr62 len4, address wraps
    cyc(); send(1'b1, 5, 62, 4); #1;
    for (int w = 1; w <= 7; w++) begin
      cyc(); cmd_vld = 1'b0;
      wdata_vld = (w <= 4);
      wdata = (w <= 4) ? wd[w-1] : '0;
      gnt = (w <= 4); #1;
      chk("t2_req_vld", 64'(req.vld), 64'(w <= 4));
      chk("t2_wdata_rdy", 64'(wdata_rdy), 64'(w <= 4));
      if (w <= 4) begin
        chk("t2_addr", 64'(req.addr), 64'((62 + w - 1) % 64));
        chk("t2_data", req.data, wd[w-1]);
        chk("t2_type", 64'(req.access_type), 64'(1));
      end
      chk("t2_rd_vld", 64'(rd_vld), 64'(0));
      chk("t2_done", 64'(done), 64'(w == 6));
      chk("t2_cmd_rdy", 64'(cmd_rdy), 64'(w >= 6));
    end

    // read ptr1 addr20 len3 with stalling grants
    cyc(); send(1'b0, 1, 20, 3); #1;
    rdcnt = 0;
    for (int w = 1; w <= 10; w++) begin
      cyc(); cmd_vld = 1'b0;
      gnt = (w <= 6) ? (g[w-1] != 0) : 1'b0; #1;
      chk("t3_req_vld", 64'(req.vld), 64'(w <= 6));
      if (w <= 6) begin
        chk("t3_alen", 64'(req.access_length), 64'(al[w-1]));
        chk("t3_addr", 64'(req.addr), 64'(ea[w-1]));
        chk("t3_ptr", 64'(req.vec_reg_ptr), 64'(1));
      end
      if (rd_vld) rdcnt++;
      chk("t3_rd_vld", 64'(rd_vld), 64'(w == 3 || w == 6 || w == 8));
      if (w == 3) chk("t3_rd_d0", rd_data, mk(1, 20));
      if (w == 6) chk("t3_rd_d1", rd_data, mk(1, 21));
      if (w == 8) chk("t3_rd_d2", rd_data, mk(1, 22));
      chk("t3_done", 64'(done), 64'(w == 9));
    end
    chk("t3_rd_count", 64'(rdcnt), 64'(3));

    // zero-length command, stray grant held
    cyc(); send(1'b0, 2, 7, 0); gnt = 1'b1; #1;
    for (int w = 1; w <= 3; w++) begin
      cyc(); cmd_vld = 1'b0; #1;
      chk("t4_req_vld", 64'(req.vld), 64'(0));
      chk("t4_done", 64'(done), 64'(w == 2));
      chk("t4_cmd_rdy", 64'(cmd_rdy), 64'(w >= 2));
    end
    gnt = 1'b0;

    // reset mid-read after 2 of 5 grants
    cyc(); send(1'b0, 2, 5, 5); #1;
    for (int w = 1; w <= 2; w++) begin
      cyc(); cmd_vld = 1'b0; gnt = 1'b1; #1;
      chk("t5_addr", 64'(req.addr), 64'(5 + w - 1));
    end
    cyc(); gnt = 1'b0; reset = 1'b0; #1;
    chk("t5_req_vld", 64'(req.vld), 64'(0));
    chk("t5_rd_vld", 64'(rd_vld), 64'(0));
    chk("t5_rd_data", rd_data, 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    chk("t5_wdata_rdy", 64'(wdata_rdy), 64'(0));
    cyc(); reset = 1'b1;
    cyc(); send(1'b0, 7, 63, 1); #1;
    chk("t5_cmd_rdy", 64'(cmd_rdy), 64'(1));
    for (int w = 1; w <= 5; w++) begin
      cyc(); cmd_vld = 1'b0; gnt = (w == 1); #1;
      chk("t5b_req_vld", 64'(req.vld), 64'(w == 1));
      if (w == 1) begin
        chk("t5b_addr", 64'(req.addr), 64'(63));
        chk("t5b_alen", 64'(req.access_length), 64'(1));
      end
      chk("t5b_rd_vld", 64'(rd_vld), 64'(w == 3));
      if (w == 3) chk("t5b_rd_data", rd_data, mk(7, 63));
      chk("t5b_done", 64'(done), 64'(w == 4));
    end
    chk("t5b_err", 64'(err_unexp_rsp), 64'(0));

    // unexpected response in IDLE
    cyc(); inj_rsp = 1'b1; #1;
    cyc(); inj_rsp = 1'b0; #1;
    chk("t6_rd_vld", 64'(rd_vld), 64'(0));
    chk("t6_err", 64'(err_unexp_rsp), 64'(1));
    for (int w = 0; w < 3; w++) begin
      cyc(); #1;
      chk("t6_err_sticky", 64'(err_unexp_rsp), 64'(1));
    end
    cyc(); reset = 1'b0; #1;
    chk("t6_err_clr", 64'(err_unexp_rsp), 64'(0));
    cyc(); reset = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
